// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX hazard/stall controller.
// Control vector bit order: pc_write_en, if_id_write_en, id_ex_bubble, id_ex_hold, ex_mem_bubble.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write_en;
        logic if_id_write_en;
        logic id_ex_bubble;
        logic id_ex_hold;
        logic ex_mem_bubble;
    } stall_ctrl_t;

    // Reset forces a bubble into ID/EX and freezes fetch.
    localparam stall_ctrl_t STALL_CTRL_RESET    = stall_ctrl_t'(5'b00100);
    localparam stall_ctrl_t STALL_CTRL_NORMAL   = stall_ctrl_t'(5'b11000);
    localparam stall_ctrl_t STALL_CTRL_MUL_HOLD = stall_ctrl_t'(5'b00011);
    localparam stall_ctrl_t STALL_CTRL_LOAD_USE = stall_ctrl_t'(5'b00100);

endpackage

// File: rtl/mul_stall_counter.sv
// Tracks a multi-cycle multiply occupying EX and raises mul_hold on all
// but its last EX cycle.
//
// state    | meaning
// RUN      | no multiply being tracked; a multiply in EX triggers a hold
// MUL_BUSY | multiply in EX; hold while mcnt != 0, last EX cycle when mcnt == 0
module mul_stall_counter
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ex_is_mult,
    output logic mul_hold
);

    localparam int MCNT_W = ($clog2(MUL_CYCLES) > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam bit MUL_EN = (MUL_CYCLES >= 2);
    localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'((MUL_CYCLES >= 2) ? MUL_CYCLES - 2 : 0);

    hz_state_e         state_q, state_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic              mul_trig;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        mul_trig = (state_q == RUN) && ex_is_mult && MUL_EN;
        mul_hold = mul_trig || ((state_q == MUL_BUSY) && (mcnt_q != '0));
        case (state_q)
            RUN: begin
                if (mul_trig) begin
                    state_d = MUL_BUSY;
                    mcnt_d  = MCNT_LOAD;
                end
            end
            MUL_BUSY: begin
                // ex_is_mult is ignored here: it is still the same multiply.
                if (mcnt_q != '0) begin
                    mcnt_d = mcnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                mcnt_d  = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_hazard_stall_unit.sv
// ID/EX hazard controller: load-use bubble, multiply hold, and a saturating
// count of cycles in which the PC was frozen.
module id_ex_hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_is_mult,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_bubble,
    output logic [CNT_W-1:0] stall_count
);

    logic             mul_hold;
    logic             load_use;
    stall_ctrl_t      ctrl;
    logic [CNT_W-1:0] stall_count_q;

    mul_stall_counter #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_stall_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .ex_is_mult (ex_is_mult),
        .mul_hold   (mul_hold)
    );

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    // Reset override is combinational so the pipeline is gated the moment reset drops.
    always_comb begin
        ctrl = STALL_CTRL_NORMAL;
        if (!reset_n) begin
            ctrl = STALL_CTRL_RESET;
        end else if (mul_hold) begin
            ctrl = STALL_CTRL_MUL_HOLD;
        end else if (load_use) begin
            ctrl = STALL_CTRL_LOAD_USE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
        end else if (!ctrl.pc_write_en && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign pc_write_en    = ctrl.pc_write_en;
    assign if_id_write_en = ctrl.if_id_write_en;
    assign id_ex_bubble   = ctrl.id_ex_bubble;
    assign id_ex_hold     = ctrl.id_ex_hold;
    assign ex_mem_bubble  = ctrl.ex_mem_bubble;
    assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_id_ex_hazard_stall_unit.sv
// Scoreboard bench for id_ex_hazard_stall_unit: directed hazard scenarios then
// randomized traffic, checked against a multiply-age reference model.
module tb_id_ex_hazard_stall_unit;

    localparam int MC      = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 3;
    localparam int MAX16   = (1 << CNT_W) - 1;
    localparam int MAX3    = (1 << CNT_W_S) - 1;

    logic               clock;
    logic               reset_n;
    logic [4:0]         id_rs, id_rt, ex_rt;
    logic               id_uses_rs, id_uses_rt, ex_mem_read, ex_is_mult;
    logic               pc_write_en, if_id_write_en, id_ex_bubble, id_ex_hold, ex_mem_bubble;
    logic [CNT_W-1:0]   stall_count;
    logic               pc_we_s, if_id_we_s, bubble_s, hold_s, exm_bubble_s;
    logic [CNT_W_S-1:0] stall_count_s;

    typedef struct packed {
        logic [4:0]         ctrl;
        logic [CNT_W-1:0]   cnt;
        logic [CNT_W_S-1:0] cnt_s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    // Model state: age of the multiply in EX (-1 = none) and both stall counts.
    int   mul_age = -1;
    int   cnt16   = 0;
    int   cnt3    = 0;

    id_ex_hazard_stall_unit #(.MUL_CYCLES(MC), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_is_mult(ex_is_mult), .pc_write_en(pc_write_en),
        .if_id_write_en(if_id_write_en), .id_ex_bubble(id_ex_bubble),
        .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble), .stall_count(stall_count)
    );

    id_ex_hazard_stall_unit #(.MUL_CYCLES(MC), .CNT_W(CNT_W_S)) dut_sat (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_is_mult(ex_is_mult), .pc_write_en(pc_we_s),
        .if_id_write_en(if_id_we_s), .id_ex_bubble(bubble_s),
        .id_ex_hold(hold_s), .ex_mem_bubble(exm_bubble_s), .stall_count(stall_count_s)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One pipeline cycle: drive inputs just after the edge, predict, push.
    task automatic cyc(input bit rst_n, input int rs, input int rt, input bit urs,
                       input bit urt, input bit mr, input int ert, input bit mul);
        exp_t e;
        bit   hold, lu;
        @(posedge clock);
        #1;
        reset_n     = rst_n;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        ex_mem_read = mr;
        ex_rt       = 5'(ert);
        ex_is_mult  = mul;
        if (!rst_n) begin
            mul_age = -1;
            cnt16   = 0;
            cnt3    = 0;
            e.ctrl  = 5'b00100;
            e.cnt   = '0;
            e.cnt_s = '0;
            exp_q.push_back(e);
            pushed++;
        end else begin
            if (mul_age < 0 && mul && MC >= 2) mul_age = 0;
            hold = (mul_age >= 0) && (mul_age <= MC - 2);
            lu   = mr && (ert != 0) && ((urs && rs == ert) || (urt && rt == ert));
            if (hold)    e.ctrl = 5'b00011;
            else if (lu) e.ctrl = 5'b00100;
            else         e.ctrl = 5'b11000;
            e.cnt   = CNT_W'(cnt16);
            e.cnt_s = CNT_W_S'(cnt3);
            exp_q.push_back(e);
            pushed++;
            if (mul_age >= 0) mul_age = (mul_age + 1 >= MC) ? -1 : mul_age + 1;
            if (!e.ctrl[4]) begin
                cnt16 = (cnt16 < MAX16) ? cnt16 + 1 : MAX16;
                cnt3  = (cnt3 < MAX3) ? cnt3 + 1 : MAX3;
            end
        end
    endtask

    function automatic int rnd_reg();
        int sel;
        sel = int'($urandom_range(0, 4));
        if (sel == 0) return 0;
        if (sel == 1) return int'($urandom_range(0, 31));
        return int'($urandom_range(7, 9));
    endfunction

    initial begin : monitor
        exp_t e;
        logic [4:0] got;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                got = {pc_write_en, if_id_write_en, id_ex_bubble, id_ex_hold, ex_mem_bubble};
                checks++;
                if (got !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got=%b exp=%b", $time, got, e.ctrl);
                end
                got = {pc_we_s, if_id_we_s, bubble_s, hold_s, exm_bubble_s};
                checks++;
                if (got !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl_sat t=%0t got=%b exp=%b", $time, got, e.ctrl);
                end
                checks++;
                if (stall_count !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, e.cnt);
                end
                checks++;
                if (stall_count_s !== e.cnt_s) begin
                    errors++;
                    $display("FAIL stall_count_sat t=%0t got=%0d exp=%0d", $time, stall_count_s, e.cnt_s);
                end
            end
        end
    end

    initial begin : stimulus
        int mul_run;
        bit mul;
        reset_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = '0; ex_is_mult = 1'b0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use, then the bubble clears it.
        cyc(1, 8, 0, 1, 0, 1, 8, 0);
        cyc(1, 8, 0, 1, 0, 0, 8, 0);
        // $zero destination and unused rt operand.
        cyc(1, 0, 0, 1, 0, 1, 0, 0);
        cyc(1, 0, 9, 0, 0, 1, 9, 0);
        // Two back-to-back multiplies.
        for (int i = 0; i < 2 * MC; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Load-use with trigger, then load-use on the last multiply cycle.
        cyc(1, 8, 0, 1, 0, 1, 8, 1);
        for (int i = 0; i < MC - 2; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 9, 0, 1, 1, 9, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Reset mid-multiply, release with no residual hold.
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Drive the narrow counter into saturation.
        for (int i = 0; i < 12; i++) cyc(1, 5, 0, 1, 0, 1, 5, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        mul_run = 0;
        for (int n = 0; n < 800; n++) begin
            if (mul_run > 0) begin
                mul = 1'b1;
                mul_run--;
            end else if ($urandom_range(0, 5) == 0) begin
                mul = 1'b1;
                mul_run = int'($urandom_range(0, 8));
            end else begin
                mul = 1'b0;
            end
            cyc(($urandom_range(0, 60) != 0), rnd_reg(), rnd_reg(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), rnd_reg(), mul);
        end

        repeat (3) @(posedge clock);
        checks++;
        if (exp_q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain left=%0d popped=%0d pushed=%0d", exp_q.size(), popped, pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
